oled_spi_stream: RTL and testbench

- Parametrised successor to the fixed OLED SPI driver for the SSD1306-class Pmod/on-board OLED.
- Performs the full panel power sequence (VDD, reset pulse, VBAT) with cycle-count delays set by parameters.
- Exposes a valid/ready byte-stream port so upstream logic (debug console, framebuffer scanner) can push command or data bytes.
- Performs an orderly shutdown: display-off command, then VBAT off, then VDD off.

---
 rtl/oled_spi_pkg.sv | 25 ++
 rtl/spi_byte_tx.sv | 86 ++++++++
 rtl/oled_spi_stream.sv | 144 ++++++++++++++
 tb/tb_oled_spi_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_spi_pkg.sv
// Shared definitions for the SSD1306-class OLED SPI stream driver:
// power-sequencer states, the display-off command and a sizing helper.
package oled_spi_pkg;

  typedef enum logic [3:0] {
    OFF,
    VDD_WAIT,
    RES_LOW,
    RES_WAIT,
    VBAT_WAIT,
    RUN,
    SHIFT,
    SHUT_VBAT,
    SHUT_VDD
  } state_t;

  localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-3 SPI byte shifter: MSB first, CLK_DIV cycles per SCLK half-period,
// cs held low for the 8 bits, done pulses in the final cycle of the byte.
module spi_byte_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  output logic       o_done,
  output logic       o_cs,
  output logic       o_sclk,
  output logic       o_sdin,
  output logic       o_dc
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'((CLK_DIV > 1) ? CLK_DIV - 2 : 0);

  logic          r_active;
  logic          r_gap;
  logic          r_hi;
  logic [DW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_shreg;
  logic          r_dc;

  logic w_div_end;
  logic w_last_hi;
  logic w_done;

  assign w_div_end = (r_div == DIV_LAST);
  assign w_last_hi = r_active && !r_gap && r_hi && w_div_end && (r_bit == 3'd0);
  // The cs-high gap is CLK_DIV cycles including the idle cycle in which the
  // next byte is accepted, so only CLK_DIV-1 gap cycles are spent in here.
  assign w_done    = (CLK_DIV == 1) ? w_last_hi
                                    : (r_active && r_gap && (r_div == GAP_LAST));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_gap    <= 1'b0;
      r_hi     <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_dc     <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_gap    <= 1'b0;
      r_hi     <= 1'b0;
      r_div    <= '0;
      r_bit    <= 3'd7;
      r_shreg  <= i_byte;
      r_dc     <= i_dc;
    end else if (r_active) begin
      if (w_done) begin
        r_active <= 1'b0;
        r_gap    <= 1'b0;
        r_hi     <= 1'b0;
        r_div    <= '0;
      end else if (r_gap) begin
        r_div <= r_div + 1'b1;
      end else if (w_div_end) begin
        r_div <= '0;
        r_hi  <= !r_hi;
        if (r_hi) begin
          r_shreg <= {r_shreg[6:0], 1'b0};
          r_bit   <= r_bit - 3'd1;
          if (r_bit == 3'd0) r_gap <= 1'b1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign o_done = w_done;
  assign o_cs   = !(r_active && !r_gap);
  assign o_sclk = !(r_active && !r_gap && !r_hi);
  assign o_sdin = r_shreg[7];
  assign o_dc   = r_dc;

endmodule

// File: rtl/oled_spi_stream.sv
// OLED panel driver: VDD/reset/VBAT power sequencing, a valid/ready byte
// stream forwarded over SPI, and an orderly display-off shutdown.
module oled_spi_stream #(
  parameter int CLK_DIV    = 4,
  parameter int VDD_DELAY  = 1000,
  parameter int RES_PULSE  = 3,
  parameter int VBAT_DELAY = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       shutdown,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_dc,
  output logic       in_ready,
  output logic       powered,
  output logic       cs,
  output logic       sdin,
  output logic       sclk,
  output logic       dc,
  output logic       res,
  output logic       vbatc,
  output logic       vddc
);

  import oled_spi_pkg::*;

  localparam int CW = $clog2(max3(VDD_DELAY, RES_PULSE, VBAT_DELAY) + 1);
  localparam logic [CW-1:0] VDD_LAST  = CW'(VDD_DELAY - 1);
  localparam logic [CW-1:0] RES_LAST  = CW'(RES_PULSE - 1);
  localparam logic [CW-1:0] VBAT_LAST = CW'(VBAT_DELAY - 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_shut_byte;

  logic       w_cnt_en;
  logic       w_start;
  logic [7:0] w_tx_byte;
  logic       w_tx_dc;
  logic       w_tx_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= OFF;
      r_cnt       <= '0;
      r_shut_byte <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_cnt_en)     r_cnt <= r_cnt + 1'b1;
      if (w_start) r_shut_byte <= !in_valid;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_en  = 1'b0;
    w_start   = 1'b0;
    w_tx_byte = in_data;
    w_tx_dc   = in_dc;
    in_ready  = 1'b0;
    powered   = 1'b0;
    res       = 1'b1;
    vbatc     = 1'b1;
    vddc      = 1'b0;
    unique case (r_state)
      OFF: begin
        vddc = 1'b1;
        if (!shutdown) w_next = VDD_WAIT;
      end
      VDD_WAIT: begin
        w_cnt_en = 1'b1;
        if (shutdown)                w_next = SHUT_VBAT;
        else if (r_cnt == VDD_LAST)  w_next = RES_LOW;
      end
      RES_LOW: begin
        w_cnt_en = 1'b1;
        res      = 1'b0;
        if (shutdown)                w_next = SHUT_VBAT;
        else if (r_cnt == RES_LAST)  w_next = RES_WAIT;
      end
      RES_WAIT: begin
        w_cnt_en = 1'b1;
        if (shutdown)                w_next = SHUT_VBAT;
        else if (r_cnt == RES_LAST)  w_next = VBAT_WAIT;
      end
      VBAT_WAIT: begin
        w_cnt_en = 1'b1;
        vbatc    = 1'b0;
        if (shutdown)                w_next = SHUT_VBAT;
        else if (r_cnt == VBAT_LAST) w_next = RUN;
      end
      RUN: begin
        vbatc    = 1'b0;
        in_ready = 1'b1;
        powered  = 1'b1;
        // A pending upstream byte wins over shutdown; shutdown is seen next idle cycle.
        if (in_valid) begin
          w_start = 1'b1;
          w_next  = SHIFT;
        end else if (shutdown) begin
          w_start   = 1'b1;
          w_tx_byte = CMD_DISPLAY_OFF;
          w_tx_dc   = 1'b0;
          w_next    = SHIFT;
        end
      end
      SHIFT: begin
        vbatc = 1'b0;
        if (w_tx_done) w_next = r_shut_byte ? SHUT_VBAT : RUN;
      end
      SHUT_VBAT: begin
        w_cnt_en = 1'b1;
        if (r_cnt == VBAT_LAST) w_next = SHUT_VDD;
      end
      SHUT_VDD: begin
        vddc   = 1'b1;
        w_next = OFF;
      end
      default: begin
        vddc   = 1'b1;
        w_next = OFF;
      end
    endcase
  end

  spi_byte_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_start (w_start),
    .i_byte  (w_tx_byte),
    .i_dc    (w_tx_dc),
    .o_done  (w_tx_done),
    .o_cs    (cs),
    .o_sclk  (sclk),
    .o_sdin  (sdin),
    .o_dc    (dc)
  );

endmodule

// File: tb/tb_oled_spi_stream.sv
// Directed self-checking bench for oled_spi_stream with short delays.
module tb_oled_spi_stream;

  localparam int CLK_DIV    = 2;
  localparam int VDD_DELAY  = 10;
  localparam int RES_PULSE  = 5;
  localparam int VBAT_DELAY = 20;
  localparam int BYTE_CYC   = 17 * CLK_DIV;
  localparam int UP_CYC     = 1 + VDD_DELAY + 2 * RES_PULSE + VBAT_DELAY;
  // {cs,sclk,sdin,dc,res,vbatc,vddc,in_ready,powered}
  localparam logic [8:0] RST_VEC = 9'b1_1_0_0_1_1_1_0_0;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       shutdown = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_dc    = 1'b0;
  logic in_ready, powered, cs, sdin, sclk, dc, res, vbatc, vddc;
  logic [8:0] w_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] mon_word = '0;
  int          mon_bits = 0;

  always #5 clock = ~clock;

  assign w_out = {cs, sclk, sdin, dc, res, vbatc, vddc, in_ready, powered};

  // Panel-side view: sample sdin on SCLK rising edges while selected.
  always @(posedge sclk) begin
    if (!cs) begin
      mon_word = {mon_word[30:0], sdin};
      mon_bits++;
    end
  end

  oled_spi_stream #(
    .CLK_DIV    (CLK_DIV),
    .VDD_DELAY  (VDD_DELAY),
    .RES_PULSE  (RES_PULSE),
    .VBAT_DELAY (VBAT_DELAY)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .shutdown (shutdown),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_dc    (in_dc),
    .in_ready (in_ready),
    .powered  (powered),
    .cs       (cs),
    .sdin     (sdin),
    .sclk     (sclk),
    .dc       (dc),
    .res      (res),
    .vbatc    (vbatc),
    .vddc     (vddc)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (w_out !== RST_VEC) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", w_out, RST_VEC);
    end
  endtask

  task automatic test_powerup();
    int t_vdd = -1, t_resl = -1, t_resh = -1, t_vbat = -1, t_pwr = -1;
    bit cs_act = 0;
    reset = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clock);
      if (!cs || !sclk) cs_act = 1;
      if (t_vdd < 0 && !vddc) t_vdd = i;
      if (t_resl < 0 && !res) t_resl = i;
      if (t_resl >= 0 && t_resh < 0 && res) t_resh = i;
      if (t_vbat < 0 && !vbatc) t_vbat = i;
      if (powered) begin
        t_pwr = i;
        break;
      end
    end
    checks++;
    if (t_vdd !== 1) begin
      errors++; $display("FAIL vdd_fall: got %0d expected 1", t_vdd);
    end
    checks++;
    if (t_resl - t_vdd !== VDD_DELAY) begin
      errors++; $display("FAIL res_fall_delay: got %0d expected %0d", t_resl - t_vdd, VDD_DELAY);
    end
    checks++;
    if (t_resh - t_resl !== RES_PULSE) begin
      errors++; $display("FAIL res_low_width: got %0d expected %0d", t_resh - t_resl, RES_PULSE);
    end
    checks++;
    if (t_vbat - t_resh !== RES_PULSE) begin
      errors++; $display("FAIL vbat_fall_delay: got %0d expected %0d", t_vbat - t_resh, RES_PULSE);
    end
    checks++;
    if (t_pwr - t_vbat !== VBAT_DELAY) begin
      errors++; $display("FAIL powered_delay: got %0d expected %0d", t_pwr - t_vbat, VBAT_DELAY);
    end
    checks++;
    if (in_ready !== 1'b1 || cs_act) begin
      errors++; $display("FAIL run_entry: in_ready=%b spi_activity=%0d expected 1/0", in_ready, cs_act);
    end
  endtask

  task automatic test_byte();
    int base = mon_bits, cs_low = 0, t_rdy = -1;
    bit dc_bad = 0;
    in_valid = 1'b1; in_data = 8'hA5; in_dc = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (!cs) begin
        cs_low++;
        if (dc !== 1'b1) dc_bad = 1;
      end
      if (in_ready) begin
        t_rdy = i;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (mon_word[7:0] !== 8'hA5 || mon_bits - base !== 8) begin
      errors++; $display("FAIL byte_bits: got %h/%0d bits expected a5/8", mon_word[7:0], mon_bits - base);
    end
    checks++;
    if (cs_low !== 16 * CLK_DIV || dc_bad) begin
      errors++; $display("FAIL byte_cs_dc: cs_low=%0d dc_bad=%0d expected %0d/0", cs_low, dc_bad, 16 * CLK_DIV);
    end
    checks++;
    if (t_rdy !== BYTE_CYC) begin
      errors++; $display("FAIL byte_ready_return: got %0d expected %0d", t_rdy, BYTE_CYC);
    end
  endtask

  task automatic test_back_to_back();
    int base = mon_bits, h1 = -1, h2 = -1, gap = 0;
    bit seen_low = 0, gap_done = 0;
    in_valid = 1'b1; in_data = 8'h00; in_dc = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if (in_valid && in_ready) begin
        if (h1 < 0) h1 = i;
        else if (h2 < 0) h2 = i;
      end
      if (!cs) begin
        if (seen_low && gap > 0) gap_done = 1;
        seen_low = 1;
      end else if (seen_low && !gap_done) begin
        gap++;
      end
      if (h2 >= 0 && i > h2 && in_ready) break;
      if (h1 >= 0 && i > h1) in_data = 8'hFF;
      if (h2 >= 0 && i > h2) in_valid = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b0;
    checks++;
    if (h1 < 0 || h2 - h1 !== BYTE_CYC) begin
      errors++; $display("FAIL b2b_spacing: got %0d expected %0d", h2 - h1, BYTE_CYC);
    end
    checks++;
    if (gap !== CLK_DIV) begin
      errors++; $display("FAIL b2b_cs_gap: got %0d expected %0d", gap, CLK_DIV);
    end
    checks++;
    if (mon_word[15:0] !== 16'h00FF || mon_bits - base !== 16) begin
      errors++; $display("FAIL b2b_bits: got %h/%0d bits expected 00ff/16", mon_word[15:0], mon_bits - base);
    end
  endtask

  task automatic test_shutdown_idle();
    int base = mon_bits, t_vb = -1, t_vd = -1, t_up = -1;
    bit dc_bad = 0;
    shutdown = 1'b1;
    @(negedge clock);
    checks++;
    if (powered !== 1'b0 || cs !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL shut_first_shift: powered=%b cs=%b in_ready=%b expected 0/0/0", powered, cs, in_ready);
    end
    for (int i = 1; i <= 200; i++) begin
      if (!cs && dc !== 1'b0) dc_bad = 1;
      if (t_vb < 0 && vbatc) t_vb = i;
      if (t_vd < 0 && vddc) begin
        t_vd = i;
        break;
      end
      @(negedge clock);
    end
    checks++;
    if (mon_word[7:0] !== 8'hAE || mon_bits - base !== 8 || dc_bad) begin
      errors++; $display("FAIL shut_cmd: got %h/%0d bits dc_bad=%0d expected ae/8/0", mon_word[7:0], mon_bits - base, dc_bad);
    end
    checks++;
    if (t_vb !== BYTE_CYC) begin
      errors++; $display("FAIL shut_vbat_rise: got %0d expected %0d", t_vb, BYTE_CYC);
    end
    checks++;
    if (t_vd - t_vb !== VBAT_DELAY) begin
      errors++; $display("FAIL shut_vdd_rise: got %0d expected %0d", t_vd - t_vb, VBAT_DELAY);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (vddc !== 1'b1 || vbatc !== 1'b1 || powered !== 1'b0 || cs !== 1'b1) begin
      errors++; $display("FAIL off_hold: vddc=%b vbatc=%b powered=%b cs=%b expected 1/1/0/1", vddc, vbatc, powered, cs);
    end
    shutdown = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (powered) begin
        t_up = i;
        break;
      end
    end
    checks++;
    if (t_up !== UP_CYC) begin
      errors++; $display("FAIL restart_powerup: got %0d expected %0d", t_up, UP_CYC);
    end
  endtask

  task automatic test_shutdown_mid_byte();
    int base = mon_bits, t_vb = -1, t_vd = -1, dc1 = 0, dc0 = 0;
    in_valid = 1'b1; in_data = 8'h3C; in_dc = 1'b1;
    for (int i = 1; i <= 250; i++) begin
      @(negedge clock);
      if (i == 1) in_valid = 1'b0;
      if (i == 5) shutdown = 1'b1;
      if (!cs) begin
        if (dc === 1'b1) dc1++;
        else dc0++;
      end
      if (t_vb < 0 && vbatc) t_vb = i;
      if (vddc) begin
        t_vd = i;
        break;
      end
    end
    checks++;
    if (mon_word[15:0] !== 16'h3CAE || mon_bits - base !== 16) begin
      errors++; $display("FAIL mid_byte_seq: got %h/%0d bits expected 3cae/16", mon_word[15:0], mon_bits - base);
    end
    checks++;
    if (dc1 !== 16 * CLK_DIV || dc0 !== 16 * CLK_DIV) begin
      errors++; $display("FAIL mid_byte_dc: dc1=%0d dc0=%0d expected %0d/%0d", dc1, dc0, 16 * CLK_DIV, 16 * CLK_DIV);
    end
    checks++;
    if (t_vb !== 2 * BYTE_CYC) begin
      errors++; $display("FAIL mid_byte_vbat: got %0d expected %0d", t_vb, 2 * BYTE_CYC);
    end
    checks++;
    if (t_vd - t_vb !== VBAT_DELAY) begin
      errors++; $display("FAIL mid_byte_vdd: got %0d expected %0d", t_vd - t_vb, VBAT_DELAY);
    end
    @(negedge clock);
  endtask

  task automatic test_shutdown_vdd_wait();
    int t_vd = -1, t_up = -1;
    bit bad = 0;
    shutdown = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (!cs || !sclk || !res || !vbatc) bad = 1;
      if (i == 3) begin
        checks++;
        if (vddc !== 1'b0) begin
          errors++; $display("FAIL vdd_wait_entry: vddc=%b expected 0", vddc);
        end
        shutdown = 1'b1;
      end
      if (i > 3 && vddc) begin
        t_vd = i;
        break;
      end
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL vdd_wait_quiet: spi/res/vbat activity=%0d expected 0", bad);
    end
    // One cycle to leave VDD_WAIT, then the full VBAT-off delay.
    checks++;
    if (t_vd - 3 !== VBAT_DELAY + 1) begin
      errors++; $display("FAIL vdd_wait_shutdown: got %0d expected %0d", t_vd - 3, VBAT_DELAY + 1);
    end
    @(negedge clock);
    shutdown = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (powered) begin
        t_up = i;
        break;
      end
    end
    checks++;
    if (t_up !== UP_CYC) begin
      errors++; $display("FAIL restart_after_abort: got %0d expected %0d", t_up, UP_CYC);
    end
  endtask

  task automatic test_reset_mid_shift();
    in_valid = 1'b1; in_data = 8'h81; in_dc = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (cs !== 1'b0 || dc !== 1'b1) begin
      errors++; $display("FAIL mid_shift_precond: cs=%b dc=%b expected 0/1", cs, dc);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (w_out !== RST_VEC) begin
      errors++; $display("FAIL async_reset: got %b expected %b", w_out, RST_VEC);
    end
    @(negedge clock);
    checks++;
    if (w_out !== RST_VEC) begin
      errors++; $display("FAIL reset_hold: got %b expected %b", w_out, RST_VEC);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_byte();
    test_back_to_back();
    test_shutdown_idle();
    test_shutdown_mid_byte();
    test_shutdown_vdd_wait();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
